// File: rtl/display_scan_ctrl.sv
// Eight-digit common-anode 7-segment scan controller with a double-buffered load port.
// Each digit slot opens with a dark blanking interval; new contents swap in at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 100
) (
    input  logic        CLK_100MHZ,
    input  logic        RST_N,
    input  logic        LOAD,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  EN_MASK,
    output logic        PENDING,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP_N,
    output logic        FRAME_TICK
);

    localparam int unsigned SLOT  = CLK_HZ / SCAN_HZ;
    localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    typedef enum logic {StBlank, StShow} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             slot_end, boundary;

    logic             pend_q, pend_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [7:0]       pend_dp_q, pend_dp_d;
    logic [7:0]       pend_mask_q, pend_mask_d;
    logic [31:0]      act_data_q, act_data_d;
    logic [7:0]       act_dp_q, act_dp_d;
    logic [7:0]       act_mask_q, act_mask_d;

    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_n_q, dp_n_d;
    logic             tick_q;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot counter and digit index; the FSM state always tracks the counter phase.
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == 3'd7);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
        state_d  = (cnt_d < CNT_BLANK) ? StBlank : StShow;
    end

    // A boundary transfer takes priority; a LOAD on that cycle is dropped.
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_mask_d = pend_mask_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_mask_d  = act_mask_q;
        if (boundary && pend_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            act_mask_d = pend_mask_q;
            pend_d     = 1'b0;
        end else if (LOAD && !pend_q) begin
            pend_data_d = DATA;
            pend_dp_d   = DP_IN;
            pend_mask_d = EN_MASK;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        nibble = act_data_q[{idx_q, 2'b00} +: 4];
        an_d   = 8'hFF;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        case (state_q)
            StBlank: begin
            end
            StShow: begin
                if (act_mask_q[idx_q]) begin
                    an_d[idx_q] = 1'b0;
                    seg_d       = hex7(nibble);
                    dp_n_d      = ~act_dp_q[idx_q];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StBlank;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            pend_q      <= 1'b0;
            pend_data_q <= 32'h0;
            pend_dp_q   <= 8'h0;
            pend_mask_q <= 8'h0;
            act_data_q  <= 32'h0;
            act_dp_q    <= 8'h0;
            act_mask_q  <= 8'h0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_n_q      <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_mask_q <= pend_mask_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_mask_q  <= act_mask_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_n_q      <= dp_n_d;
            tick_q      <= boundary;
        end
    end

    assign PENDING    = pend_q;
    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP_N       = dp_n_q;
    assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: positional frame model plus directed scenarios.
module tb_display_scan_ctrl;

    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 8 * SLOT;

    logic        CLK_100MHZ = 1'b0;
    logic        RST_N      = 1'b0;
    logic        LOAD       = 1'b0;
    logic [31:0] DATA       = 32'h0;
    logic [7:0]  DP_IN      = 8'h0;
    logic [7:0]  EN_MASK    = 8'h0;
    logic        PENDING;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP_N;
    logic        FRAME_TICK;

    int checks = 0;
    int errors = 0;

    // Model: position within the frame is simply elapsed cycles since reset release mod FRAME.
    int          pos;
    int          last_p;
    logic        m_pend;
    logic [31:0] m_pdata, m_adata;
    logic [7:0]  m_pdp, m_pmask, m_adp, m_amask;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp_n, exp_tick, exp_pend;
    logic [6:0]  hex_tab [16];

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    display_scan_ctrl #(
        .CLK_HZ      (1000),
        .SCAN_HZ     (100),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .CLK_100MHZ(CLK_100MHZ),
        .RST_N     (RST_N),
        .LOAD      (LOAD),
        .DATA      (DATA),
        .DP_IN     (DP_IN),
        .EN_MASK   (EN_MASK),
        .PENDING   (PENDING),
        .AN        (AN),
        .SEG       (SEG),
        .DP_N      (DP_N),
        .FRAME_TICK(FRAME_TICK)
    );

    function automatic logic [17:0] obs();
        return {AN, SEG, DP_N, FRAME_TICK, PENDING};
    endfunction

    function automatic logic [17:0] expv();
        return {exp_an, exp_seg, exp_dp_n, exp_tick, exp_pend};
    endfunction

    task automatic model_reset();
        pos     = 0;
        m_pend  = 1'b0;
        m_pdata = '0; m_pdp = '0; m_pmask = '0;
        m_adata = '0; m_adp = '0; m_amask = '0;
    endtask

    // Predict the registered outputs for the coming edge, then advance one clock.
    task automatic tick();
        int p, d;
        p        = pos % FRAME;
        d        = p / SLOT;
        last_p   = p;
        exp_an   = 8'hFF;
        exp_seg  = 7'h7F;
        exp_dp_n = 1'b1;
        if ((p % SLOT) >= BLANK && m_amask[d]) begin
            exp_an[d] = 1'b0;
            exp_seg   = hex_tab[m_adata[4*d +: 4]];
            exp_dp_n  = ~m_adp[d];
        end
        exp_tick = (p == FRAME - 1);
        if (exp_tick && m_pend) begin
            m_adata = m_pdata; m_adp = m_pdp; m_amask = m_pmask;
            m_pend  = 1'b0;
        end else if (LOAD && !m_pend) begin
            m_pdata = DATA; m_pdp = DP_IN; m_pmask = EN_MASK;
            m_pend  = 1'b1;
        end
        exp_pend = m_pend;
        @(posedge CLK_100MHZ);
        #1;
        pos++;
    endtask

    task automatic test_reset();
        @(negedge CLK_100MHZ);
        RST_N = 1'b1;
        model_reset();
        DATA = $urandom; DP_IN = $urandom; EN_MASK = 8'hFF;
        for (int i = 0; i < FRAME + 15; i++) begin
            LOAD = (i == 0) || (i == FRAME + 13);
            tick();
            LOAD = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL reset_pre_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
        checks++;
        if (AN === 8'hFF || PENDING !== 1'b1) begin
            errors++; $display("FAIL reset_precondition got AN=%h PEND=%b exp lit digit, PEND=1", AN, PENDING);
        end
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({AN, SEG, DP_N, PENDING, FRAME_TICK} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_async got AN=%h SEG=%h DP_N=%b PEND=%b TICK=%b exp FF 7F 1 0 0",
                               AN, SEG, DP_N, PENDING, FRAME_TICK);
        end
        repeat (3) @(posedge CLK_100MHZ);
        #1;
        checks++;
        if ({AN, SEG, DP_N, PENDING} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_held got AN=%h SEG=%h DP_N=%b PEND=%b", AN, SEG, DP_N, PENDING);
        end
        @(negedge CLK_100MHZ);
        RST_N = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (AN !== 8'hFF || PENDING !== 1'b0 || obs() !== expv()) begin
                errors++; $display("FAIL reset_dark p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
    endtask

    task automatic test_basic_load();
        int fe_cnt = 0;
        DATA = 32'h76543210; DP_IN = 8'h01; EN_MASK = 8'hFF; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        checks++;
        if (PENDING !== 1'b1) begin
            errors++; $display("FAIL basic_pending_rise got=%b exp=1", PENDING);
        end
        for (int i = 0; i < FRAME + 1 && m_pend; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic_wait_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
        checks++;
        if (PENDING !== 1'b0) begin
            errors++; $display("FAIL basic_pending_fall got=%b exp=0", PENDING);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL basic_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
            if (AN === 8'hFE) fe_cnt++;
            if (last_p >= BLANK && last_p < SLOT) begin
                checks++;
                if ({AN, SEG, DP_N} !== {8'hFE, 7'b1000000, 1'b0}) begin
                    errors++; $display("FAIL basic_digit0 got AN=%h SEG=%b DP_N=%b exp FE 1000000 0", AN, SEG, DP_N);
                end
            end
            if (last_p >= 7 * SLOT + BLANK) begin
                checks++;
                if (AN !== 8'h7F || SEG !== 7'b1111000) begin
                    errors++; $display("FAIL basic_digit7 got AN=%h SEG=%b exp 7F 1111000", AN, SEG);
                end
            end
        end
        checks++;
        if (fe_cnt != SLOT - BLANK) begin
            errors++; $display("FAIL basic_low_cycles got=%0d exp=%0d", fe_cnt, SLOT - BLANK);
        end
    endtask

    task automatic test_mask();
        int last_tick = -1;
        int n_ticks   = 0;
        DATA = $urandom; DP_IN = $urandom; EN_MASK = 8'h0F; LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        for (int i = 0; i < FRAME + 1 && m_pend; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL mask_wait_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL mask_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
            if (last_p >= 4 * SLOT) begin
                checks++;
                if (AN !== 8'hFF) begin
                    errors++; $display("FAIL mask_dark p=%0d got AN=%h exp FF", last_p, AN);
                end
            end
            if (FRAME_TICK === 1'b1) begin
                n_ticks++;
                if (last_tick >= 0) begin
                    checks++;
                    if (i - last_tick != FRAME) begin
                        errors++; $display("FAIL mask_tick_period got=%0d exp=%0d", i - last_tick, FRAME);
                    end
                end
                last_tick = i;
            end
        end
        checks++;
        if (n_ticks != 2) begin
            errors++; $display("FAIL mask_tick_count got=%0d exp=2", n_ticks);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, c;
        a = $urandom;
        c = $urandom;
        if (c[3:0] == a[3:0]) c[3:0] = ~a[3:0];
        while (pos % FRAME != 0) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL b2b_align_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            LOAD    = (i == 0) || (i == 7) || (i == FRAME + 3);
            DATA    = (i == 0) ? a : ((i == 7) ? ~a : c);
            DP_IN   = $urandom;
            EN_MASK = 8'hFF;
            tick();
            LOAD = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL b2b_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
            if (i == 7 || i == FRAME + 3) begin
                checks++;
                if (PENDING !== 1'b1) begin
                    errors++; $display("FAIL b2b_pending i=%0d got=%b exp=1", i, PENDING);
                end
            end
            if (last_p >= BLANK && last_p < SLOT && i >= FRAME) begin
                checks++;
                if (SEG !== hex_tab[(i < 2 * FRAME) ? a[3:0] : c[3:0]]) begin
                    errors++; $display("FAIL b2b_shown i=%0d got SEG=%b exp=%b", i, SEG,
                                       hex_tab[(i < 2 * FRAME) ? a[3:0] : c[3:0]]);
                end
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [31:0] d1, x;
        logic [7:0]  prev_an = 8'hFF;
        d1 = $urandom;
        x  = $urandom;
        while (pos % FRAME != 0) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL bnd_align_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
        EN_MASK = 8'hFF;
        for (int i = 0; i < 4 * FRAME; i++) begin
            LOAD  = (i == FRAME - 1) || (i == 2 * FRAME + 5) || (i == 3 * FRAME - 1);
            DATA  = (i == FRAME - 1) ? d1 : ((i == 2 * FRAME + 5) ? x : ~x);
            DP_IN = $urandom;
            tick();
            LOAD = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL bnd_model i=%0d got=%h exp=%h", i, obs(), expv());
            end
            checks++;
            if ($countones(~AN) > 1 || (prev_an != 8'hFF && AN != 8'hFF && AN != prev_an)) begin
                errors++; $display("FAIL bnd_anode_rule i=%0d got AN=%h prev=%h", i, AN, prev_an);
            end
            prev_an = AN;
            if (i == FRAME - 1 || i == 3 * FRAME - 1) begin
                checks++;
                if (FRAME_TICK !== 1'b1 || PENDING !== (i == FRAME - 1)) begin
                    errors++; $display("FAIL bnd_handshake i=%0d got TICK=%b PEND=%b exp TICK=1 PEND=%b",
                                       i, FRAME_TICK, PENDING, i == FRAME - 1);
                end
            end
            if (last_p >= BLANK && last_p < SLOT && i >= 2 * FRAME) begin
                checks++;
                if (SEG !== hex_tab[(i < 3 * FRAME) ? d1[3:0] : x[3:0]]) begin
                    errors++; $display("FAIL bnd_shown i=%0d got SEG=%b exp=%b", i, SEG,
                                       hex_tab[(i < 3 * FRAME) ? d1[3:0] : x[3:0]]);
                end
            end
        end
        checks++;
        if (PENDING !== 1'b0) begin
            errors++; $display("FAIL bnd_ignored_load got PEND=%b exp=0", PENDING);
        end
    endtask

    task automatic test_hex();
        for (int k = 0; k < 2; k++) begin
            DATA = (k == 0) ? 32'hFEDCBA98 : 32'h76543210;
            DP_IN = $urandom; EN_MASK = 8'hFF; LOAD = 1'b1;
            tick();
            LOAD = 1'b0;
            for (int i = 0; i < FRAME + 1 && m_pend; i++) begin
                tick();
                checks++;
                if (obs() !== expv()) begin
                    errors++; $display("FAIL hex_wait_model p=%0d got=%h exp=%h", last_p, obs(), expv());
                end
            end
            for (int i = 0; i < FRAME; i++) begin
                tick();
                if (last_p % SLOT >= BLANK) begin
                    checks++;
                    if (SEG !== hex_tab[(k == 0 ? 8 : 0) + last_p / SLOT]) begin
                        errors++; $display("FAIL hex_decode digit=%0d got=%b exp=%b", last_p / SLOT, SEG,
                                           hex_tab[(k == 0 ? 8 : 0) + last_p / SLOT]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            LOAD    = ($urandom_range(0, 19) == 0);
            DATA    = $urandom;
            DP_IN   = $urandom;
            EN_MASK = $urandom;
            tick();
            LOAD = 1'b0;
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random_model p=%0d got=%h exp=%h", last_p, obs(), expv());
            end
        end
    endtask

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();
        test_reset();
        test_basic_load();
        test_mask();
        test_back_to_back();
        test_boundary_load();
        test_hex();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
